// File: rtl/module_binary_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// module_binary_to_bcd_seq
//
// Sequential binary-to-BCD converter using the iterative shift-and-add-3
// (double-dabble) algorithm with a start/done handshake. One algorithm
// iteration is performed per clock, so a W-bit input takes W+1 cycles from
// the accepted START to the DONE pulse. Digits that do not fit in DIGITOS
// are dropped (result is magnitude mod 10^D) and flagged on OVERFLOW.
//
// Optional feature macro: BIN2BCD_SIGNED_EN
//   defined   : ENTRADA is two's complement, |x| is converted, NEGATIVO = sign
//   undefined : ENTRADA is unsigned, NEGATIVO is tied to 0
//
// Parameters
//   ANCHO_ENTRADA  binary input width W (>= 2)
//   DIGITOS        number of BCD output digits D (>= 1)
//
// Ports
//   CLK       in   rising-edge clock
//   RST_N     in   synchronous active-low reset
//   ENTRADA   in   W-bit binary value, sampled only when a start is accepted
//   START     in   conversion request (honoured in IDLE and FIN only)
//   BUSY      out  high while iterating (SHIFT state)
//   DONE      out  one-cycle pulse when a new result is presented
//   BCD       out  4*D packed digits, [3:0] = units
//   OVERFLOW  out  magnitude of last conversion was >= 10^D
//   NEGATIVO  out  sign of last conversion (0 when signed mode disabled)
// ---------------------------------------------------------------------------
module module_binary_to_bcd_seq #(
    parameter int ANCHO_ENTRADA = 8,
    parameter int DIGITOS       = 3
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic [ANCHO_ENTRADA-1:0]   ENTRADA,
    input  logic                       START,
    output logic                       BUSY,
    output logic                       DONE,
    output logic [4*DIGITOS-1:0]       BCD,
    output logic                       OVERFLOW,
    output logic                       NEGATIVO
);

    localparam int W  = ANCHO_ENTRADA;
    localparam int D  = DIGITOS;
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FIN
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            capture;

    logic [W-1:0]    shift_reg;
    logic [4*D-1:0]  scratch;
    logic            ovf_latch;
    logic [CW-1:0]   iter;

    logic [W-1:0]    magnitude;
    logic [4*D-1:0]  adjusted;
    logic [4*D-1:0]  scratch_next;
    logic [W-1:0]    shift_next;
    logic            carry_out;
    logic            last_iter;

`ifdef BIN2BCD_SIGNED_EN
    logic            sign_in;
    logic            sign_reg;

    // Two's complement magnitude. The most negative value negates to itself,
    // which read as unsigned is exactly 2^(W-1), so W bits are enough.
    always_comb begin
        sign_in   = ENTRADA[W-1];
        magnitude = sign_in ? (~ENTRADA + W'(1)) : ENTRADA;
    end
`else
    // Unsigned input is converted as-is.
    always_comb begin
        magnitude = ENTRADA;
    end
`endif

    // One double-dabble step: correct every digit >= 5 so that the following
    // doubling carries correctly into the next digit, then shift the whole
    // {scratch, shift_reg} pair left by one. The bit leaving the top digit
    // represents 10^D and therefore means the result does not fit.
    always_comb begin
        adjusted = scratch;
        for (int i = 0; i < D; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
        carry_out    = adjusted[4*D-1];
        scratch_next = {adjusted[4*D-2:0], shift_reg[W-1]};
        shift_next   = {shift_reg[W-2:0], 1'b0};
        last_iter    = (iter == LAST_ITER);
    end

    // Next-state and handshake outputs. FIN accepts a new START directly so
    // back-to-back conversions cost no extra idle cycle.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        BUSY       = 1'b0;
        DONE       = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    capture    = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                BUSY = 1'b1;
                if (last_iter) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                DONE = 1'b1;
                if (START) begin
                    capture    = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: load on capture, iterate in SHIFT, and publish the result on
    // the same edge as the final iteration so BCD/OVERFLOW are already valid
    // in the DONE cycle.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            shift_reg <= '0;
            scratch   <= '0;
            ovf_latch <= 1'b0;
            iter      <= '0;
            BCD       <= '0;
            OVERFLOW  <= 1'b0;
        end else if (capture) begin
            shift_reg <= magnitude;
            scratch   <= '0;
            ovf_latch <= 1'b0;
            iter      <= '0;
        end else if (state == SHIFT) begin
            shift_reg <= shift_next;
            scratch   <= scratch_next;
            ovf_latch <= ovf_latch | carry_out;
            iter      <= iter + CW'(1);
            if (last_iter) begin
                BCD      <= scratch_next;
                OVERFLOW <= ovf_latch | carry_out;
            end
        end
    end

`ifdef BIN2BCD_SIGNED_EN
    // Sign is captured with the input and published alongside the digits.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sign_reg <= 1'b0;
            NEGATIVO <= 1'b0;
        end else if (capture) begin
            sign_reg <= sign_in;
        end else if ((state == SHIFT) && last_iter) begin
            NEGATIVO <= sign_reg;
        end
    end
`else
    assign NEGATIVO = 1'b0;
`endif

endmodule
